// File: rtl/ber_sweep_controller_if.sv
// rtl/ber_sweep_controller_if.sv - host control, PRBS link and result record signals of the BER sweep sequencer
interface ber_sweep_controller_if;
    logic        start;
    logic        abort;
    logic [15:0] rate_start;
    logic [15:0] rate_step;
    logic [7:0]  num_steps;
    logic        send_data;
    logic [31:0] error_bits_in;
    logic [31:0] total_bits_in;
    logic [15:0] error_rate;
    logic        get_word;
    logic        busy;
    logic        done;
    logic        result_valid;
    logic [7:0]  result_step;
    logic [15:0] result_rate;
    logic [31:0] result_errors;
    logic [31:0] result_total;
    logic        result_timeout;

    modport master (
        input  start, abort, rate_start, rate_step, num_steps,
        input  send_data, error_bits_in, total_bits_in,
        output error_rate, get_word, busy, done,
        output result_valid, result_step, result_rate, result_errors, result_total, result_timeout
    );

    modport slave (
        output start, abort, rate_start, rate_step, num_steps,
        output send_data, error_bits_in, total_bits_in,
        input  error_rate, get_word, busy, done,
        input  result_valid, result_step, result_rate, result_errors, result_total, result_timeout
    );
endinterface

// File: rtl/ber_sweep_controller.sv
// rtl/ber_sweep_controller.sv - steps the PRBS error_rate, requests a receiver word per step and reports the counts
module ber_sweep_controller #(
    parameter int SETTLE_CYCLES   = 1000,
    parameter int GET_WORD_CYCLES = 5,
    parameter int TIMEOUT_CYCLES  = 4000000
) (
    input  logic                   clk,
    input  logic                   rst,
    ber_sweep_controller_if.master bus
);
    typedef enum logic [2:0] {IDLE, SETTLE, REQUEST, WAIT, REPORT, DONE} state_t;

    localparam logic [31:0] SETTLE_LAST   = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] GET_WORD_LAST = 32'(GET_WORD_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST  = 32'(TIMEOUT_CYCLES);

    state_t      state, state_nx;
    logic [31:0] cnt, cnt_nx;
    logic [7:0]  step, step_nx, steps, steps_nx;
    logic [15:0] rate, rate_nx, rate_inc, rate_inc_nx;
    logic        get_word, get_word_nx, busy, busy_nx, done, done_nx;
    logic        result_valid, result_valid_nx, result_timeout, result_timeout_nx;
    logic [7:0]  result_step, result_step_nx;
    logic [15:0] result_rate, result_rate_nx;
    logic [31:0] result_errors, result_errors_nx, result_total, result_total_nx;
    logic [16:0] rate_sum;
    logic        last_step;

    assign rate_sum  = {1'b0, rate} + {1'b0, rate_inc};
    assign last_step = (step == steps - 8'd1);

    always_comb begin
        state_nx          = state;
        cnt_nx            = cnt;
        step_nx           = step;
        steps_nx          = steps;
        rate_nx           = rate;
        rate_inc_nx       = rate_inc;
        result_valid_nx   = 1'b0;
        result_timeout_nx = result_timeout;
        result_step_nx    = result_step;
        result_rate_nx    = result_rate;
        result_errors_nx  = result_errors;
        result_total_nx   = result_total;

        // Abort beats everything, including a send_data in the same WAIT cycle.
        if (bus.abort && state != IDLE && state != DONE) begin
            state_nx = DONE;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        steps_nx    = bus.num_steps;
                        rate_inc_nx = bus.rate_step;
                        rate_nx     = bus.rate_start;
                        step_nx     = '0;
                        cnt_nx      = '0;
                        state_nx    = (bus.num_steps == 8'd0) ? DONE : SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt_nx   = '0;
                        state_nx = REQUEST;
                    end else begin
                        cnt_nx = cnt + 32'd1;
                    end
                end
                REQUEST: begin
                    if (cnt == GET_WORD_LAST) begin
                        cnt_nx   = '0;
                        state_nx = WAIT;
                    end else begin
                        cnt_nx = cnt + 32'd1;
                    end
                end
                WAIT: begin
                    if (bus.send_data) begin
                        result_errors_nx  = bus.error_bits_in;
                        result_total_nx   = bus.total_bits_in;
                        result_timeout_nx = 1'b0;
                        result_valid_nx   = 1'b1;
                        result_step_nx    = step;
                        result_rate_nx    = rate;
                        cnt_nx            = '0;
                        state_nx          = REPORT;
                    end else if (cnt == TIMEOUT_LAST) begin
                        result_errors_nx  = '0;
                        result_total_nx   = '0;
                        result_timeout_nx = 1'b1;
                        result_valid_nx   = 1'b1;
                        result_step_nx    = step;
                        result_rate_nx    = rate;
                        cnt_nx            = '0;
                        state_nx          = REPORT;
                    end else begin
                        cnt_nx = cnt + 32'd1;
                    end
                end
                REPORT: begin
                    if (last_step) begin
                        state_nx = DONE;
                    end else begin
                        step_nx  = step + 8'd1;
                        rate_nx  = rate_sum[16] ? 16'hFFFF : rate_sum[15:0];
                        state_nx = SETTLE;
                    end
                end
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end

        // Status outputs are registered copies of the next state.
        get_word_nx = (state_nx == REQUEST);
        busy_nx     = (state_nx inside {SETTLE, REQUEST, WAIT, REPORT});
        done_nx     = (state_nx == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            step           <= '0;
            steps          <= '0;
            rate           <= '0;
            rate_inc       <= '0;
            get_word       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            result_valid   <= 1'b0;
            result_timeout <= 1'b0;
            result_step    <= '0;
            result_rate    <= '0;
            result_errors  <= '0;
            result_total   <= '0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            step           <= step_nx;
            steps          <= steps_nx;
            rate           <= rate_nx;
            rate_inc       <= rate_inc_nx;
            get_word       <= get_word_nx;
            busy           <= busy_nx;
            done           <= done_nx;
            result_valid   <= result_valid_nx;
            result_timeout <= result_timeout_nx;
            result_step    <= result_step_nx;
            result_rate    <= result_rate_nx;
            result_errors  <= result_errors_nx;
            result_total   <= result_total_nx;
        end
    end

    assign bus.error_rate     = rate;
    assign bus.get_word       = get_word;
    assign bus.busy           = busy;
    assign bus.done           = done;
    assign bus.result_valid   = result_valid;
    assign bus.result_step    = result_step;
    assign bus.result_rate    = result_rate;
    assign bus.result_errors  = result_errors;
    assign bus.result_total   = result_total;
    assign bus.result_timeout = result_timeout;
endmodule
